grf_mp: RTL and testbench

Parametrised multi-port general register file, successor to the single-write/two-read GRF in the pipelined CPU. It provides NUM_RD combinational read ports with same-cycle write-through bypass, and two write ports (A = writeback stage, B = secondary retire path). A per-register pending-write counter scoreboard lets the hazard unit see which registers have in-flight producers.

---
 rtl/grf_mp.sv | 99 +++++++++
 tb/tb_grf_mp.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/grf_mp.sv
// grf_mp: multi-port register file with write-through bypass and a per-register pending-producer scoreboard; define GRF_TRACE_EN to print effective writes
module grf_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 3,
    parameter int CNT_W  = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wa_en,
    input  logic [ADDR_W-1:0]        wa_addr,
    input  logic [DATA_W-1:0]        wa_data,
    input  logic [31:0]              wa_pc,
    input  logic                     wa_retire,
    input  logic                     wb_en,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic [31:0]              wb_pc,
    input  logic                     wb_retire,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic                     ovf
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy_vec;
    logic [DEPTH-1:0]  sat_vec;
    logic              wa_eff;
    logic              wb_eff;

    // B is dropped when A targets the same register in the same cycle
    assign wa_eff = wa_en && wa_addr != '0;
    assign wb_eff = wb_en && wb_addr != '0 && !(wa_eff && wa_addr == wb_addr);

    // register storage; register 0 is never written
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else begin
            if (wa_eff) regs[wa_addr] <= wa_data;
            if (wb_eff) regs[wb_addr] <= wb_data;
        end
    end

    for (genvar r = 0; r < DEPTH; r++) begin : g_cnt
        logic [CNT_W-1:0] q;
        logic [CNT_W-1:0] nxt;
        logic             inc;
        logic [CNT_W:0]   dec;
        logic [CNT_W:0]   up;
        logic [CNT_W:0]   diff;
        assign inc  = (r != 0) && iss_en && iss_addr == ADDR_W'(r);
        assign dec  = (CNT_W+1)'(wa_en && wa_retire && wa_addr == ADDR_W'(r))
                    + (CNT_W+1)'(wb_en && wb_retire && wb_addr == ADDR_W'(r));
        assign up   = {1'b0, q} + (CNT_W+1)'(inc);
        assign diff = up - dec;
        assign sat_vec[r]  = inc && q == '1 && dec == '0;
        assign nxt  = sat_vec[r] ? '1 : (up <= dec ? '0 : diff[CNT_W-1:0]);
        assign busy_vec[r] = q != '0;
        // pending-producer count, clamped at 0 and saturating at max
        always_ff @(posedge clk) begin
            if (reset) q <= '0;
            else       q <= nxt;
        end
    end

    // overflow flag is sticky until reset
    always_ff @(posedge clk) begin
        if (reset)         ovf <= 1'b0;
        else if (|sat_vec) ovf <= 1'b1;
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] a;
        assign a = rd_addr[k*ADDR_W +: ADDR_W];
        assign rd_data[k*DATA_W +: DATA_W] = a == '0                   ? '0
                                           : (wa_en && wa_addr == a) ? wa_data
                                           : (wb_en && wb_addr == a) ? wb_data
                                           : regs[a];
        assign rd_busy[k] = a != '0 && busy_vec[a];
    end

`ifdef GRF_TRACE_EN
    // trace of effective writes, A before B
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (wa_eff) $display("%d@%h: $%d <= %h", $time, wa_pc, wa_addr, wa_data);
            if (wb_eff) $display("%d@%h: $%d <= %h", $time, wb_pc, wb_addr, wb_data);
        end
    end
`else
    logic unused_pc;
    assign unused_pc = ^{wa_pc, wb_pc};
`endif
endmodule

// File: tb/tb_grf_mp.sv
// tb_grf_mp: directed self-checking bench for grf_mp
module tb_grf_mp;
    logic        clk = 1'b0;
    logic        reset;
    logic [14:0] rd_addr;
    logic [95:0] rd_data;
    logic [2:0]  rd_busy;
    logic        wa_en, wa_retire, wb_en, wb_retire, iss_en;
    logic [4:0]  wa_addr, wb_addr, iss_addr;
    logic [31:0] wa_data, wb_data, wa_pc, wb_pc;
    logic        ovf;
    int          n_cmp = 0;
    int          n_err = 0;

    grf_mp dut (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data), .wa_pc(wa_pc), .wa_retire(wa_retire),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .wb_pc(wb_pc), .wb_retire(wb_retire),
        .iss_en(iss_en), .iss_addr(iss_addr), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        wa_en = 0; wa_retire = 0; wa_addr = 0; wa_data = 0; wa_pc = 32'h100;
        wb_en = 0; wb_retire = 0; wb_addr = 0; wb_data = 0; wb_pc = 32'h200;
        iss_en = 0; iss_addr = 0;
    endtask

    task automatic test_reset;
        idle();
        reset = 1;
        rd_addr = {5'd31, 5'd1, 5'd0};
        tick();
        tick();
        reset = 0;
        #1;
        n_cmp++;
        if (rd_data !== 96'h0) begin n_err++; $display("FAIL reset_data got %h want 0", rd_data); end
        n_cmp++;
        if (rd_busy !== 3'b000) begin n_err++; $display("FAIL reset_busy got %b want 000", rd_busy); end
        n_cmp++;
        if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b want 0", ovf); end
    endtask

    task automatic test_bypass;
        idle();
        wa_en = 1; wa_addr = 5; wa_data = 32'hDEADBEEF;
        wb_en = 1; wb_addr = 6; wb_data = 32'h0000CAFE;
        rd_addr = {5'd1, 5'd6, 5'd5};
        #1;
        n_cmp++;
        if (rd_data[31:0] !== 32'hDEADBEEF) begin n_err++; $display("FAIL bypass_a got %h want deadbeef", rd_data[31:0]); end
        n_cmp++;
        if (rd_data[63:32] !== 32'h0000CAFE) begin n_err++; $display("FAIL bypass_b got %h want 0000cafe", rd_data[63:32]); end
        n_cmp++;
        if (rd_data[95:64] !== 32'h0) begin n_err++; $display("FAIL bypass_other got %h want 0", rd_data[95:64]); end
        tick();
        idle();
        #1;
        n_cmp++;
        if (rd_data[31:0] !== 32'hDEADBEEF) begin n_err++; $display("FAIL stored_a got %h want deadbeef", rd_data[31:0]); end
        n_cmp++;
        if (rd_data[63:32] !== 32'h0000CAFE) begin n_err++; $display("FAIL stored_b got %h want 0000cafe", rd_data[63:32]); end
    endtask

    task automatic test_collision;
        idle();
        wa_en = 1; wa_addr = 7; wa_data = 32'h11;
        wb_en = 1; wb_addr = 7; wb_data = 32'h22;
        rd_addr = {5'd7, 5'd0, 5'd0};
        #1;
        n_cmp++;
        if (rd_data[95:64] !== 32'h11) begin n_err++; $display("FAIL collide_bypass got %h want 11", rd_data[95:64]); end
        tick();
        idle();
        #1;
        n_cmp++;
        if (rd_data[95:64] !== 32'h11) begin n_err++; $display("FAIL collide_stored got %h want 11", rd_data[95:64]); end
    endtask

    task automatic test_reg0;
        idle();
        wa_en = 1; wa_addr = 0; wa_data = 32'h55;
        wb_en = 1; wb_addr = 0; wb_data = 32'h66;
        iss_en = 1; iss_addr = 0;
        rd_addr = {5'd0, 5'd0, 5'd0};
        #1;
        n_cmp++;
        if (rd_data !== 96'h0) begin n_err++; $display("FAIL reg0_bypass got %h want 0", rd_data); end
        tick();
        idle();
        #1;
        n_cmp++;
        if (rd_data !== 96'h0) begin n_err++; $display("FAIL reg0_stored got %h want 0", rd_data); end
        n_cmp++;
        if (rd_busy !== 3'b000) begin n_err++; $display("FAIL reg0_busy got %b want 000", rd_busy); end
    endtask

    task automatic test_saturation;
        idle();
        rd_addr = {5'd0, 5'd0, 5'd3};
        iss_en = 1; iss_addr = 3;
        #1;
        n_cmp++;
        if (rd_busy[0] !== 1'b0) begin n_err++; $display("FAIL sat_same_cycle got %b want 0", rd_busy[0]); end
        tick();
        tick();
        tick();
        iss_en = 0;
        #1;
        n_cmp++;
        if (rd_busy[0] !== 1'b1) begin n_err++; $display("FAIL sat_busy3 got %b want 1", rd_busy[0]); end
        n_cmp++;
        if (ovf !== 1'b0) begin n_err++; $display("FAIL sat_ovf_at3 got %b want 0", ovf); end
        iss_en = 1;
        tick();
        iss_en = 0;
        #1;
        n_cmp++;
        if (ovf !== 1'b1) begin n_err++; $display("FAIL sat_ovf got %b want 1", ovf); end
        wa_en = 1; wa_retire = 1; wa_addr = 3; wa_data = 32'h3;
        wb_en = 1; wb_retire = 1; wb_addr = 3; wb_data = 32'h4;
        tick();
        idle();
        #1;
        n_cmp++;
        if (rd_busy[0] !== 1'b1) begin n_err++; $display("FAIL sat_after_two_retires got %b want 1", rd_busy[0]); end
        wa_en = 1; wa_retire = 1; wa_addr = 3; wa_data = 32'h5;
        tick();
        idle();
        #1;
        n_cmp++;
        if (rd_busy[0] !== 1'b0) begin n_err++; $display("FAIL sat_after_three_retires got %b want 0", rd_busy[0]); end
    endtask

    task automatic test_issue_retire;
        idle();
        rd_addr = {5'd10, 5'd0, 5'd9};
        iss_en = 1; iss_addr = 9;
        tick();
        wa_en = 1; wa_retire = 1; wa_addr = 9; wa_data = 32'h99;
        tick();
        idle();
        #1;
        n_cmp++;
        if (rd_busy[0] !== 1'b1) begin n_err++; $display("FAIL iss_ret_hold got %b want 1", rd_busy[0]); end
        wb_en = 1; wb_retire = 1; wb_addr = 9; wb_data = 32'h98;
        tick();
        idle();
        #1;
        n_cmp++;
        if (rd_busy[0] !== 1'b0) begin n_err++; $display("FAIL iss_ret_zero got %b want 0", rd_busy[0]); end
        wa_en = 1; wa_retire = 1; wa_addr = 9;
        tick();
        idle();
        iss_en = 1; iss_addr = 9;
        tick();
        idle();
        wa_en = 1; wa_retire = 1; wa_addr = 9;
        tick();
        idle();
        #1;
        n_cmp++;
        if (rd_busy[0] !== 1'b0) begin n_err++; $display("FAIL underflow_clamp got %b want 0", rd_busy[0]); end
        iss_en = 1; iss_addr = 10;
        tick();
        tick();
        idle();
        wa_en = 1; wa_retire = 1; wa_addr = 10; wa_data = 32'hA;
        wb_en = 1; wb_retire = 1; wb_addr = 10; wb_data = 32'hB;
        tick();
        idle();
        #1;
        n_cmp++;
        if (rd_busy[2] !== 1'b0) begin n_err++; $display("FAIL collide_retire got %b want 0", rd_busy[2]); end
        n_cmp++;
        if (rd_data[95:64] !== 32'hA) begin n_err++; $display("FAIL collide_retire_data got %h want a", rd_data[95:64]); end
        n_cmp++;
        if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %b want 1", ovf); end
    endtask

    task automatic test_mid_reset;
        idle();
        iss_en = 1; iss_addr = 12;
        tick();
        idle();
        reset = 1;
        wa_en = 1; wa_addr = 14; wa_data = 32'h77;
        iss_en = 1; iss_addr = 12;
        tick();
        reset = 0;
        idle();
        rd_addr = {5'd14, 5'd12, 5'd5};
        #1;
        n_cmp++;
        if (rd_data !== 96'h0) begin n_err++; $display("FAIL midreset_data got %h want 0", rd_data); end
        n_cmp++;
        if (rd_busy !== 3'b000) begin n_err++; $display("FAIL midreset_busy got %b want 000", rd_busy); end
        n_cmp++;
        if (ovf !== 1'b0) begin n_err++; $display("FAIL midreset_ovf got %b want 0", ovf); end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_collision();
        test_reg0();
        test_saturation();
        test_issue_retire();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
